// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// write-strobe default and byte-assembly sizing.
package imem_loader_pkg;

    localparam int WE_CYCLES_DEFAULT = 1;
    localparam int WE_CNT_W          = 4;
    localparam int BYTES_PER_WORD    = 4;
    localparam int BYTE_IDX_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SETUP   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four little-endian stream bytes into one 32-bit word. The word
// output already contains the byte being accepted this cycle.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [31:0]           word_q;

    always_comb begin
        word = word_q;
        if (byte_valid) begin
            word[{byte_idx, 3'b000} +: 8] = byte_data;
        end
    end

    assign word_done = byte_valid && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // Clearing on start or reset guarantees a partial word never leaks into the next load.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
            word_q   <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory through the debug write port while
// holding the core in reset; releases the core once the last word is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WE_CYCLES = WE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        debug_imem_oe,
    output logic        debug_imem_we,
    output logic [31:0] debug_imem_addr,
    output logic [31:0] debug_imem_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output state_t      dbg_state
);

    localparam logic [WE_CNT_W-1:0] WE_LAST = WE_CNT_W'(WE_CYCLES - 1);

    state_t              state;
    logic [15:0]         remaining;
    logic [WE_CNT_W-1:0] we_cnt;
    logic                byte_fire;
    logic                accept_start;
    logic                word_done;
    logic [31:0]         word;
    logic [1:0]          addr_lsb_unused;

    // Byte stream handshake: a byte moves on a rising clk edge where rx_valid
    // and rx_ready are both high; rx_ready is high only in COLLECT, so bytes
    // offered in any other state simply wait and are never consumed.
    assign byte_fire       = rx_valid && rx_ready;
    assign accept_start    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign addr_lsb_unused = base_addr[1:0];
    assign debug_imem_oe   = 1'b1;
    assign dbg_state       = state;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_start),
        .byte_valid (byte_fire),
        .byte_data  (rx_data),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rx_ready        <= 1'b0;
            debug_imem_we   <= 1'b1;
            debug_imem_addr <= '0;
            debug_imem_data <= '0;
            cpu_rst         <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            remaining       <= '0;
            we_cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        debug_imem_addr <= {2'b00, base_addr[31:2]};
                        remaining       <= word_count;
                        if (word_count == '0) begin
                            state   <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state    <= ST_COLLECT;
                            rx_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            cpu_rst  <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (word_done) begin
                        state           <= ST_SETUP;
                        rx_ready        <= 1'b0;
                        debug_imem_data <= word;
                    end
                end

                ST_SETUP: begin
                    state         <= ST_WRITE;
                    debug_imem_we <= 1'b0;
                    we_cnt        <= '0;
                end

                ST_WRITE: begin
                    if (we_cnt == WE_LAST) begin
                        state         <= ST_HOLD;
                        debug_imem_we <= 1'b1;
                    end else begin
                        we_cnt <= we_cnt + WE_CNT_W'(1);
                    end
                end

                // Address advances only when leaving HOLD so it stays put for the whole write window.
                ST_HOLD: begin
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state           <= ST_COLLECT;
                        rx_ready        <= 1'b1;
                        debug_imem_addr <= debug_imem_addr + 32'd1;
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    rx_ready      <= 1'b0;
                    debug_imem_we <= 1'b1;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    cpu_rst       <= 1'b1;
                end
            endcase
        end
    end

endmodule
